banco_wr_arbiter: RTL and testbench

- Round-robin arbiter sharing the single write port of the register bank (ptr_wr / data_wr / wr_en) between NREQ requesters.
- Example requesters: ALU writeback, load unit, CSR path.
- Each requester uses a valid/ready handshake. The winner's pointer and data are registered and presented to the bank one cycle after the grant.
- Sits between the writeback sources and the register bank's write inputs.

---
 rtl/banco_wr_arbiter.sv | 105 ++++++++++
 tb/tb_banco_wr_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/banco_wr_arbiter.sv
// banco_wr_arbiter: round-robin arbiter for the register bank's single write port.
//
// Each requester i offers a write through a valid/ready handshake. One
// requester is granted per cycle, combinationally. The scan starts at a
// rotating priority pointer and wraps around. The winner's pointer and data
// are registered, so the write reaches the bank one cycle after the grant.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active low
//   req_valid  [NREQ]             requester i has a pending write
//   req_ptr    [NREQ*$clog2(N)]   flattened destination pointers, slice i
//   req_data   [NREQ*Bits]        flattened write data, slice i
//   req_ready  [NREQ]             one-hot (or zero) combinational grant
//   wr_stall   blocks all new grants while high
//   wr_en      registered write enable to the bank
//   ptr_wr     registered destination pointer
//   data_wr    registered write data
//   wr_src     index of the requester that owns the current write
//   busy       some valid requester is left unserved this cycle
//
// Optional build macro ZERO_REG_DISCARD_EN: when defined, grants that target
// pointer 0 are still consumed, but they never raise wr_en. As a result,
// register x0 is never written.
module banco_wr_arbiter #(
    parameter int N    = 32,
    parameter int Bits = 64,
    parameter int NREQ = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ*$clog2(N)-1:0]   req_ptr,
    input  logic [NREQ*Bits-1:0]        req_data,
    output logic [NREQ-1:0]             req_ready,
    input  logic                        wr_stall,
    output logic                        wr_en,
    output logic [$clog2(N)-1:0]        ptr_wr,
    output logic [Bits-1:0]             data_wr,
    output logic [$clog2(NREQ)-1:0]     wr_src,
    output logic                        busy
);
    localparam int PW = $clog2(N);
    localparam int SW = $clog2(NREQ);

    logic [SW-1:0]   prio_q, prio_d;
    logic [SW-1:0]   wr_src_q, wr_src_d;
    logic            wr_en_q, wr_en_d;
    logic [PW-1:0]   ptr_wr_q, ptr_wr_d;
    logic [Bits-1:0] data_wr_q, data_wr_d;
    logic            grant;
    int              gnt_i;
    int              idx;

    // Scan from prio upward, wrapping; the first valid requester wins.
    always_comb begin
        req_ready = '0;
        grant     = 1'b0;
        gnt_i     = 0;
        idx       = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(prio_q) + k) % NREQ;
            if (!grant && !wr_stall && req_valid[idx]) begin
                grant = 1'b1;
                gnt_i = idx;
            end
        end
        if (grant) req_ready[gnt_i] = 1'b1;
    end

    always_comb begin
        prio_d    = grant ? SW'((gnt_i + 1) % NREQ) : prio_q;
        wr_src_d  = grant ? SW'(gnt_i) : wr_src_q;
        ptr_wr_d  = grant ? req_ptr[gnt_i*PW +: PW] : ptr_wr_q;
        data_wr_d = grant ? req_data[gnt_i*Bits +: Bits] : data_wr_q;
`ifdef ZERO_REG_DISCARD_EN
        // A grant to x0 still uses up its cycle and advances priority, but no write is issued.
        wr_en_d   = grant && (ptr_wr_d != '0);
`else
        wr_en_d   = grant;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio_q    <= '0;
            wr_src_q  <= '0;
            wr_en_q   <= 1'b0;
            ptr_wr_q  <= '0;
            data_wr_q <= '0;
        end else begin
            prio_q    <= prio_d;
            wr_src_q  <= wr_src_d;
            wr_en_q   <= wr_en_d;
            ptr_wr_q  <= ptr_wr_d;
            data_wr_q <= data_wr_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign ptr_wr  = ptr_wr_q;
    assign data_wr = data_wr_q;
    assign wr_src  = wr_src_q;
    assign busy    = |(req_valid & ~req_ready);
endmodule

// File: tb/tb_banco_wr_arbiter.sv
// tb_banco_wr_arbiter: directed self-checking bench for banco_wr_arbiter (NREQ=3, N=32, Bits=64).
module tb_banco_wr_arbiter;
    localparam int N    = 32;
    localparam int Bits = 64;
    localparam int NREQ = 3;
    localparam int PW   = 5;

    logic                 clk;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*PW-1:0]   req_ptr;
    logic [NREQ*Bits-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 wr_stall;
    logic                 wr_en;
    logic [PW-1:0]        ptr_wr;
    logic [Bits-1:0]      data_wr;
    logic [1:0]           wr_src;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    logic [NREQ-1:0] pend;

    banco_wr_arbiter #(.N(N), .Bits(Bits), .NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ptr(req_ptr),
        .req_data(req_data), .req_ready(req_ready), .wr_stall(wr_stall),
        .wr_en(wr_en), .ptr_wr(ptr_wr), .data_wr(data_wr), .wr_src(wr_src),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Protocol monitor: a valid left unserved must still be valid on the next edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) pend = '0;
        else begin
            if (|(pend & ~req_valid)) begin
                checks++;
                errors++;
                $display("FAIL protocol: valid dropped without grant pend=%b valid=%b", pend, req_valid);
            end
            pend = req_valid & ~req_ready;
        end
    end

    task automatic test_reset();
        rst = 1'b0; req_valid = '0; req_ptr = '0; req_data = '0; wr_stall = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (ptr_wr !== '0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", ptr_wr); end
        checks++; if (data_wr !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data_wr); end
        checks++; if (wr_src !== '0) begin errors++; $display("FAIL reset_src got %0d exp 0", wr_src); end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL idle_ready got %b exp 000", req_ready); end
            checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_out wr_en=%b busy=%b exp 0 0", wr_en, busy); end
            checks++; if (ptr_wr !== '0 || data_wr !== '0) begin errors++; $display("FAIL idle_regs ptr=%0d data=%h exp 0 0", ptr_wr, data_wr); end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int e;
        for (int i = 0; i < NREQ; i++) begin
            req_ptr[i*PW +: PW] = PW'(10 + i);
            req_data[i*Bits +: Bits] = Bits'(100 + i);
        end
        req_valid = 3'b111;
        for (int c = 0; c < 9; c++) begin
            e = c % 3;
            @(negedge clk);
            checks++; if (req_ready !== 3'(1 << e)) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", c, req_ready, 3'(1 << e)); end
            @(posedge clk); #1;
            checks++; if (wr_en !== 1'b1 || wr_src !== 2'(e)) begin errors++; $display("FAIL rr_write[%0d] wr_en=%b src=%0d exp 1 %0d", c, wr_en, wr_src, e); end
            checks++; if (ptr_wr !== PW'(10 + e) || data_wr !== Bits'(100 + e)) begin errors++; $display("FAIL rr_data[%0d] ptr=%0d data=%0d exp %0d %0d", c, ptr_wr, data_wr, 10 + e, 100 + e); end
            if (c >= 6) req_valid[e] = 1'b0;
        end
    endtask

    task automatic test_single();
        req_valid = 3'b010; req_ptr[1*PW +: PW] = 5'd5; req_data[1*Bits +: Bits] = 64'hDEAD_BEEF;
        @(negedge clk);
        checks++; if (req_ready !== 3'b010 || busy !== 1'b0) begin errors++; $display("FAIL single_ready got %b busy=%b exp 010 0", req_ready, busy); end
        @(posedge clk); #1;
        checks++; if (wr_en !== 1'b1 || ptr_wr !== 5'd5 || wr_src !== 2'd1) begin errors++; $display("FAIL single_write wr_en=%b ptr=%0d src=%0d exp 1 5 1", wr_en, ptr_wr, wr_src); end
        checks++; if (data_wr !== 64'hDEAD_BEEF) begin errors++; $display("FAIL single_data got %h exp deadbeef", data_wr); end
        req_valid = 3'b000;
        @(posedge clk); #1;
        checks++; if (wr_en !== 1'b0 || ptr_wr !== 5'd5) begin errors++; $display("FAIL single_after wr_en=%b ptr=%0d exp 0 5", wr_en, ptr_wr); end
    endtask

    task automatic test_stall();
        req_valid = 3'b001; req_ptr[0 +: PW] = 5'd7; req_data[0 +: Bits] = 64'h1234; wr_stall = 1'b1;
        repeat (4) begin
            @(negedge clk);
            checks++; if (req_ready !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL stall_hold ready=%b busy=%b exp 000 1", req_ready, busy); end
            @(posedge clk); #1;
            checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL stall_wr_en got %b exp 0", wr_en); end
        end
        wr_stall = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001 || busy !== 1'b0) begin errors++; $display("FAIL stall_release ready=%b busy=%b exp 001 0", req_ready, busy); end
        @(posedge clk); #1;
        req_valid = 3'b000; wr_stall = 1'b1;
        checks++; if (wr_en !== 1'b1 || ptr_wr !== 5'd7 || wr_src !== 2'd0) begin errors++; $display("FAIL stall_write wr_en=%b ptr=%0d src=%0d exp 1 7 0", wr_en, ptr_wr, wr_src); end
        @(posedge clk); #1;
        wr_stall = 1'b0;
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL stall_done wr_en got %b exp 0", wr_en); end
    endtask

    task automatic test_back_to_back();
        req_valid = 3'b101;
        req_ptr[0 +: PW] = 5'd9; req_data[0 +: Bits] = 64'hAAAA;
        req_ptr[2*PW +: PW] = 5'd9; req_data[2*Bits +: Bits] = 64'hBBBB;
        @(negedge clk);
        checks++; if (req_ready !== 3'b100 || busy !== 1'b1) begin errors++; $display("FAIL b2b_first ready=%b busy=%b exp 100 1", req_ready, busy); end
        @(posedge clk); #1;
        req_valid = 3'b001;
        checks++; if (wr_en !== 1'b1 || wr_src !== 2'd2 || data_wr !== 64'hBBBB) begin errors++; $display("FAIL b2b_w1 wr_en=%b src=%0d data=%h exp 1 2 bbbb", wr_en, wr_src, data_wr); end
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL b2b_second ready=%b exp 001", req_ready); end
        @(posedge clk); #1;
        req_valid = 3'b000;
        checks++; if (wr_en !== 1'b1 || wr_src !== 2'd0 || ptr_wr !== 5'd9 || data_wr !== 64'hAAAA) begin errors++; $display("FAIL b2b_w2 wr_en=%b src=%0d ptr=%0d data=%h exp 1 0 9 aaaa", wr_en, wr_src, ptr_wr, data_wr); end
    endtask

    task automatic test_async_reset();
        req_valid = 3'b010; req_ptr[1*PW +: PW] = 5'd3; req_data[1*Bits +: Bits] = 64'h5555;
        @(posedge clk); #1;
        req_valid = 3'b000;
        checks++; if (wr_en !== 1'b1 || ptr_wr !== 5'd3) begin errors++; $display("FAIL arst_pre wr_en=%b ptr=%0d exp 1 3", wr_en, ptr_wr); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (wr_en !== 1'b0 || ptr_wr !== '0 || data_wr !== '0 || wr_src !== '0) begin errors++; $display("FAIL arst_now wr_en=%b ptr=%0d data=%h src=%0d exp 0 0 0 0", wr_en, ptr_wr, data_wr, wr_src); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        req_valid = 3'b110; req_ptr[2*PW +: PW] = 5'd12; req_data[2*Bits +: Bits] = 64'h6666;
        @(negedge clk);
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL arst_prio ready=%b exp 010", req_ready); end
        @(posedge clk); #1;
        req_valid = 3'b100;
        checks++; if (wr_en !== 1'b1 || wr_src !== 2'd1) begin errors++; $display("FAIL arst_w1 wr_en=%b src=%0d exp 1 1", wr_en, wr_src); end
        @(negedge clk);
        checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL arst_drain ready=%b exp 100", req_ready); end
        @(posedge clk); #1;
        req_valid = 3'b000;
        checks++; if (wr_en !== 1'b1 || wr_src !== 2'd2 || ptr_wr !== 5'd12) begin errors++; $display("FAIL arst_w2 wr_en=%b src=%0d ptr=%0d exp 1 2 12", wr_en, wr_src, ptr_wr); end
    endtask

    task automatic test_zero_reg();
        logic exp_en;
`ifdef ZERO_REG_DISCARD_EN
        exp_en = 1'b0;
`else
        exp_en = 1'b1;
`endif
        req_valid = 3'b001; req_ptr[0 +: PW] = 5'd0; req_data[0 +: Bits] = 64'h77;
        @(negedge clk);
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL zero_ready got %b exp 001", req_ready); end
        @(posedge clk); #1;
        checks++; if (wr_en !== exp_en || wr_src !== 2'd0) begin errors++; $display("FAIL zero_write wr_en=%b src=%0d exp %b 0", wr_en, wr_src, exp_en); end
        if (exp_en) begin
            checks++; if (ptr_wr !== 5'd0 || data_wr !== 64'h77) begin errors++; $display("FAIL zero_data ptr=%0d data=%h exp 0 77", ptr_wr, data_wr); end
        end
        req_valid = 3'b011; req_ptr[0 +: PW] = 5'd6; req_ptr[1*PW +: PW] = 5'd4; req_data[1*Bits +: Bits] = 64'h88;
        @(negedge clk);
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL zero_prio ready=%b exp 010", req_ready); end
        @(posedge clk); #1;
        req_valid = 3'b001;
        checks++; if (wr_en !== 1'b1 || ptr_wr !== 5'd4 || wr_src !== 2'd1) begin errors++; $display("FAIL zero_next wr_en=%b ptr=%0d src=%0d exp 1 4 1", wr_en, ptr_wr, wr_src); end
        @(posedge clk); #1;
        req_valid = 3'b000;
        checks++; if (wr_en !== 1'b1 || ptr_wr !== 5'd6 || wr_src !== 2'd0) begin errors++; $display("FAIL zero_last wr_en=%b ptr=%0d src=%0d exp 1 6 0", wr_en, ptr_wr, wr_src); end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_stall();
        test_back_to_back();
        test_async_reset();
        test_zero_reg();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
